fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues word requests at pc, holds the returned
// instruction until downstream consumes it, and handles branches, flushes
// and a sticky request-timeout flag.
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruction,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [63:0] pc,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  input  logic        flush,
  input  logic [63:0] flush_pc,
  output logic        fetch_err
);

  localparam int unsigned   CW      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_MAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_VALID,
    S_DISCARD
  } state_e;

  state_e        state_q, state_d;
  logic [63:0]   pc_q, pc_d;
  logic [63:0]   flush_addr_q, flush_addr_d;
  logic [31:0]   instr_q, instr_d;
  logic          valid_q, valid_d;
  logic          req_q, req_d;
  logic          err_q, err_d;
  logic [CW-1:0] tmo_q, tmo_d;

  logic [63:0]   flush_aligned;
  logic [63:0]   branch_aligned;
  logic          consume;

  // Next-state, next-pc and registered-output computation
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    flush_addr_d   = flush_addr_q;
    instr_d        = instr_q;
    valid_d        = valid_q;
    err_d          = err_q;
    tmo_d          = tmo_q;
    flush_aligned  = flush_pc & ~64'h3;
    branch_aligned = branch_target & ~64'h3;
    consume        = valid_q & instr_ready;

    case (state_q)
      S_IDLE: begin
        // Nothing is outstanding yet, so a flush simply redirects the first fetch.
        if (flush) pc_d = flush_aligned;
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (flush) begin
          if (imem_ack) begin
            pc_d = flush_aligned;
          end else begin
            // Keep pc/request stable until the in-flight ack arrives.
            flush_addr_d = flush_aligned;
            state_d      = S_DISCARD;
          end
        end else if (imem_ack) begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
          state_d = S_VALID;
        end
      end
      S_VALID: begin
        if (flush) begin
          valid_d = 1'b0;
          pc_d    = flush_aligned;
          state_d = S_FETCH;
        end else if (consume) begin
          valid_d = 1'b0;
          pc_d    = branch_taken ? branch_aligned : pc_q + 64'd4;
          state_d = S_FETCH;
        end
      end
      S_DISCARD: begin
        if (flush) begin
          if (imem_ack) begin
            pc_d    = flush_aligned;
            state_d = S_FETCH;
          end else begin
            flush_addr_d = flush_aligned;
          end
        end else if (imem_ack) begin
          pc_d    = flush_addr_q;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase

    req_d = (state_d == S_FETCH) || (state_d == S_DISCARD);

    if (req_q && imem_ack)               tmo_d = '0;
    else if (req_q && (tmo_q != TMO_MAX)) tmo_d = tmo_q + CW'(1);

    if (tmo_d == TMO_MAX) err_d = 1'b1;
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      flush_addr_q <= RESET_PC;
      instr_q      <= '0;
      valid_q      <= 1'b0;
      req_q        <= 1'b0;
      err_q        <= 1'b0;
      tmo_q        <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      flush_addr_q <= flush_addr_d;
      instr_q      <= instr_d;
      valid_q      <= valid_d;
      req_q        <= req_d;
      err_q        <= err_d;
      tmo_q        <= tmo_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign Instruction = instr_q;
  assign instr_valid = valid_q;
  assign fetch_err   = err_q;

endmodule
